// File: rtl/wb_sched_pkg.sv
// Shared types and helpers for the Wishbone bus-grant scheduler.
package wb_sched_pkg;

   typedef enum logic [2:0] {
      WB_SCHED_IDLE  = 3'd0,
      WB_SCHED_BUSY  = 3'd1,
      WB_SCHED_TOUT  = 3'd2,
      WB_SCHED_DRAIN = 3'd3,
      WB_SCHED_GAP   = 3'd4
   } wb_sched_state_t;

   localparam int WDOG_W = 16;

   // Bits needed to hold the value v (at least one).
   function automatic int get_width(input int v);
      if (v < 2) return 1;
      return $clog2(v + 1);
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Winner selection: fixed priority among HP requesters, else round-robin
// over the remaining requesters starting just after ptr.
module wb_rr_pick
   import wb_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = get_width(N - 1)
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] hp_mask,
   input  logic [W-1:0] ptr,
   output logic         hit,
   output logic [W-1:0] idx
);

   logic [N-1:0] hp_req;
   logic [N-1:0] rr_req;
   int           j;

   assign hp_req = req & hp_mask;
   assign rr_req = req & ~hp_mask;

   // Scan in reverse search order so the last match is the first in order.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      j   = 0;
      if (|hp_req) begin
         hit = 1'b1;
         for (int i = N - 1; i >= 0; i--) begin
            if (hp_req[i]) idx = W'(i);
         end
      end else begin
         hit = |rr_req;
         for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (rr_req[j]) idx = W'(j);
         end
      end
   end

endmodule

// File: rtl/wb_sched.sv
// Registered Wishbone bus-grant scheduler with HP priority, round-robin
// sharing and a stalled-slave watchdog.
//
// state | meaning
// IDLE  | no owner, arbitrate incoming requests
// BUSY  | grant held, watchdog running while stb waits for ack/err
// TOUT  | one-cycle timeout err to master, slave side aborted
// DRAIN | slave side aborted, grant held until master drops cyc
// GAP   | one idle cycle between owners, arbitrates like IDLE
module wb_sched
   import wb_sched_pkg::*;
#(
   parameter int              MASTER_COUNT = 4,
   parameter logic [MASTER_COUNT-1:0] HP_MASK = 4'b0001,
   parameter int              TIMEOUT      = 256,
   localparam int             IDX_W        = get_width(MASTER_COUNT - 1)
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst,
   input  logic [MASTER_COUNT-1:0] req_i,
   input  logic                    bus_stb_i,
   input  logic                    bus_ack_i,
   input  logic                    bus_err_i,
   output logic [MASTER_COUNT-1:0] grant_o,
   output logic [IDX_W-1:0]        grant_idx_o,
   output logic                    grant_vld_o,
   output logic                    tout_err_o,
   output logic                    abort_o
);

   wb_sched_state_t   state, state_nxt;
   logic [IDX_W-1:0]  grant_idx, grant_idx_nxt;
   logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_clr;
   logic              wdog_hit;
   logic              pick_hit;
   logic [IDX_W-1:0]  pick_idx;

   wb_rr_pick #(
      .N (MASTER_COUNT),
      .W (IDX_W)
   ) u_pick (
      .req     (req_i),
      .hp_mask (HP_MASK),
      .ptr     (rr_ptr),
      .hit     (pick_hit),
      .idx     (pick_idx)
   );

   assign wdog_clr = !bus_stb_i || bus_ack_i || bus_err_i || (state != WB_SCHED_BUSY);
   assign wdog_hit = !wdog_clr && (wdog_cnt == WDOG_W'(TIMEOUT - 1));

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state     <= WB_SCHED_IDLE;
         grant_idx <= '0;
         rr_ptr    <= IDX_W'(MASTER_COUNT - 1);
         wdog_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_idx_nxt;
         rr_ptr    <= rr_ptr_nxt;
         wdog_cnt  <= wdog_clr ? '0 : wdog_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_idx_nxt = grant_idx;
      rr_ptr_nxt    = rr_ptr;
      case (state)
         WB_SCHED_IDLE, WB_SCHED_GAP: begin
            if (pick_hit) begin
               state_nxt     = WB_SCHED_BUSY;
               grant_idx_nxt = pick_idx;
               if (!HP_MASK[pick_idx]) rr_ptr_nxt = pick_idx;
            end else begin
               state_nxt = WB_SCHED_IDLE;
            end
         end
         WB_SCHED_BUSY: begin
            if (!req_i[grant_idx]) state_nxt = WB_SCHED_GAP;
            else if (wdog_hit)     state_nxt = WB_SCHED_TOUT;
         end
         WB_SCHED_TOUT: begin
            state_nxt = req_i[grant_idx] ? WB_SCHED_DRAIN : WB_SCHED_GAP;
         end
         WB_SCHED_DRAIN: begin
            if (!req_i[grant_idx]) state_nxt = WB_SCHED_GAP;
         end
         default: state_nxt = WB_SCHED_IDLE;
      endcase
   end

   // Outputs decode from registered state and index only.
   always_comb begin
      grant_vld_o = (state == WB_SCHED_BUSY) || (state == WB_SCHED_TOUT) ||
                    (state == WB_SCHED_DRAIN);
      tout_err_o  = (state == WB_SCHED_TOUT);
      abort_o     = (state == WB_SCHED_TOUT) || (state == WB_SCHED_DRAIN);
      grant_idx_o = grant_idx;
      grant_o     = '0;
      if (grant_vld_o) grant_o[grant_idx] = 1'b1;
   end

endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched (TIMEOUT shortened to 8).
module tb_wb_sched;

   logic       wb_clk = 1'b0;
   logic       wb_rst;
   logic [3:0] req_i;
   logic       bus_stb_i;
   logic       bus_ack_i;
   logic       bus_err_i;
   logic [3:0] grant_o;
   logic [1:0] grant_idx_o;
   logic       grant_vld_o;
   logic       tout_err_o;
   logic       abort_o;

   int checks = 0;
   int errors = 0;

   always #5 wb_clk = ~wb_clk;

   wb_sched #(
      .MASTER_COUNT (4),
      .HP_MASK      (4'b0001),
      .TIMEOUT      (8)
   ) dut (
      .wb_clk      (wb_clk),
      .wb_rst      (wb_rst),
      .req_i       (req_i),
      .bus_stb_i   (bus_stb_i),
      .bus_ack_i   (bus_ack_i),
      .bus_err_i   (bus_err_i),
      .grant_o     (grant_o),
      .grant_idx_o (grant_idx_o),
      .grant_vld_o (grant_vld_o),
      .tout_err_o  (tout_err_o),
      .abort_o     (abort_o)
   );

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output vector: {grant, idx, vld, tout, abort}
   task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic vld, input logic te, input logic ab);
      check({tag, ".grant"}, 32'(grant_o), 32'(g));
      check({tag, ".idx"},   32'(grant_idx_o), 32'(idx));
      check({tag, ".vld"},   32'(grant_vld_o), 32'(vld));
      check({tag, ".tout"},  32'(tout_err_o), 32'(te));
      check({tag, ".abort"}, 32'(abort_o), 32'(ab));
   endtask

   initial begin
      logic [1:0] rr_order [4];
      logic [3:0] bit_n;
      rr_order = '{2'd1, 2'd2, 2'd3, 2'd1};

      wb_rst = 1'b1; req_i = '0; bus_stb_i = 0; bus_ack_i = 0; bus_err_i = 0;
      step(); step();
      wb_rst = 1'b0;
      check_all("reset", 4'b0000, 2'd0, 0, 0, 0);

      // Single requester: one-cycle latency, then one GAP cycle.
      req_i = 4'b0100;
      step();
      check_all("single.grant", 4'b0100, 2'd2, 1, 0, 0);
      req_i = 4'b0000;
      step();
      check_all("single.gap", 4'b0000, 2'd2, 0, 0, 0);
      step();
      check("single.idle_vld", 32'(grant_vld_o), 32'd0);

      // Round-robin from a fresh pointer.
      wb_rst = 1'b1; step(); wb_rst = 1'b0;
      req_i = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         bit_n = 4'b0001 << rr_order[i];
         for (int c = 0; c < 3; c++) begin
            step();
            check_all($sformatf("rr%0d.c%0d", i, c), bit_n, rr_order[i], 1, 0, 0);
         end
         req_i = 4'b1110 & ~bit_n;
         step();
         check($sformatf("rr%0d.gap", i), 32'(grant_vld_o), 32'd0);
         req_i = (i < 3) ? 4'b1110 : 4'b0000;
      end
      step();
      check("rr.idle", 32'(grant_vld_o), 32'd0);

      // HP override: pointer stays at 2, so 3 follows 0.
      req_i = 4'b0100;
      step();
      check_all("hp.own2", 4'b0100, 2'd2, 1, 0, 0);
      req_i = 4'b1101;
      step();
      check_all("hp.hold2", 4'b0100, 2'd2, 1, 0, 0);
      req_i = 4'b1001;
      step();
      check("hp.gap1", 32'(grant_vld_o), 32'd0);
      step();
      check_all("hp.win0", 4'b0001, 2'd0, 1, 0, 0);
      req_i = 4'b1000;
      step();
      check("hp.gap2", 32'(grant_vld_o), 32'd0);
      req_i = 4'b1100;
      step();
      check_all("hp.next3", 4'b1000, 2'd3, 1, 0, 0);
      req_i = 4'b0000;
      step(); step();

      // Timeout after 8 stalled edges, then DRAIN until release.
      req_i = 4'b0010;
      step();
      check("tout.grant", 32'(grant_o), 32'h2);
      bus_stb_i = 1'b1;
      for (int c = 1; c <= 7; c++) step();
      check_all("tout.pre", 4'b0010, 2'd1, 1, 0, 0);
      step();
      check_all("tout.hit", 4'b0010, 2'd1, 1, 1, 1);
      step();
      check_all("tout.drain1", 4'b0010, 2'd1, 1, 0, 1);
      step();
      check_all("tout.drain2", 4'b0010, 2'd1, 1, 0, 1);
      req_i = 4'b0000; bus_stb_i = 1'b0;
      step();
      check_all("tout.gap", 4'b0000, 2'd1, 0, 0, 0);
      step();

      // ack on the threshold cycle wins and restarts the count.
      req_i = 4'b0010;
      step();
      bus_stb_i = 1'b1;
      for (int c = 1; c <= 7; c++) step();
      bus_ack_i = 1'b1;
      step();
      check_all("race.ack", 4'b0010, 2'd1, 1, 0, 0);
      bus_ack_i = 1'b0;
      for (int c = 1; c <= 7; c++) step();
      check_all("race.recount", 4'b0010, 2'd1, 1, 0, 0);
      step();
      check_all("race.tout", 4'b0010, 2'd1, 1, 1, 1);
      step();
      check_all("race.drain", 4'b0010, 2'd1, 1, 0, 1);

      // Reset mid-DRAIN.
      wb_rst = 1'b1;
      step();
      check_all("rst.drain", 4'b0000, 2'd0, 0, 0, 0);
      wb_rst = 1'b0; req_i = 4'b0110; bus_stb_i = 1'b0;
      step();
      check_all("rst.ptr", 4'b0010, 2'd1, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
